// File: rtl/cpu_bus_dma.sv
// cpu_bus_dma: multi-channel DMA bus master for the CPU-side bus.
//
// Halts the 6502 through RDY, waits for a read cycle, takes the bus and moves
// bytes as READ/WRITE pairs, then hands the bus back with a one-cycle done
// pulse for the finished channel. Channel 0 has the highest priority, and a
// granted channel always runs to completion.
//
// Ports:
//   i_clk, i_reset_n       clock (rising edge), synchronous active-low reset
//   i_start[NUM_CH]        per-channel start strobe (ignored while busy)
//   i_src_addr/i_dst_addr  packed per-channel start addresses
//   i_len                  packed per-channel byte counts (0 = no bus cycles)
//   i_dst_fixed            per-channel: destination address does not advance
//   i_cpu_rw               CPU rw output; the halt takes effect on a read cycle
//   i_data                 bus read data
//   o_rw/o_address/o_data  bus drive while owned
//   o_bus_en               DMA owns the bus
//   o_cpu_halt             pull CPU RDY low
//   o_busy, o_done         per-channel pending/active flags and done pulse
//
// Optional build macro CPU_BUS_DMA_ALIGN_EN adds an ALIGN state between HALT
// and READ so the first READ lands on an even cycle of a free-running parity bit.
module cpu_bus_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int LEN_W  = 9
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_CH-1:0]        i_start,
    input  logic [NUM_CH*ADDR_W-1:0] i_src_addr,
    input  logic [NUM_CH*ADDR_W-1:0] i_dst_addr,
    input  logic [NUM_CH*LEN_W-1:0]  i_len,
    input  logic [NUM_CH-1:0]        i_dst_fixed,
    input  logic                     i_cpu_rw,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_rw,
    output logic [ADDR_W-1:0]        o_address,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_bus_en,
    output logic                     o_cpu_halt,
    output logic [NUM_CH-1:0]        o_busy,
    output logic [NUM_CH-1:0]        o_done
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
`ifdef CPU_BUS_DMA_ALIGN_EN
        S_ALIGN = 3'd2,
`endif
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_reg, state_next;

    // Per-channel latched configuration, exposed as arrays for the grant mux.
    logic [NUM_CH-1:0] busy_vec;
    logic [NUM_CH-1:0] clear_vec;
    logic [NUM_CH-1:0] cfg_fixed;
    logic [ADDR_W-1:0] cfg_src [NUM_CH];
    logic [ADDR_W-1:0] cfg_dst [NUM_CH];
    logic [LEN_W-1:0]  cfg_len [NUM_CH];

    // Working copy of the granted channel.
    logic [CH_W-1:0]   ch_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [LEN_W-1:0]  rem_reg;
    logic              fixed_reg;
    logic [DATA_W-1:0] byte_reg;

    // Last driven bus values, held while the bus is not owned.
    logic [ADDR_W-1:0] addr_last_reg;
    logic [DATA_W-1:0] data_last_reg;

    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;

`ifdef CPU_BUS_DMA_ALIGN_EN
    logic parity_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= ~parity_reg;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              busy_ch_reg;
            logic [ADDR_W-1:0] src_ch_reg;
            logic [ADDR_W-1:0] dst_ch_reg;
            logic [LEN_W-1:0]  len_ch_reg;
            logic              fixed_ch_reg;

            // A start while busy (including the done cycle) is dropped.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    busy_ch_reg  <= 1'b0;
                    src_ch_reg   <= '0;
                    dst_ch_reg   <= '0;
                    len_ch_reg   <= '0;
                    fixed_ch_reg <= 1'b0;
                end else if (i_start[gi] && !busy_ch_reg) begin
                    busy_ch_reg  <= 1'b1;
                    src_ch_reg   <= i_src_addr[gi*ADDR_W +: ADDR_W];
                    dst_ch_reg   <= i_dst_addr[gi*ADDR_W +: ADDR_W];
                    len_ch_reg   <= i_len[gi*LEN_W +: LEN_W];
                    fixed_ch_reg <= i_dst_fixed[gi];
                end else if (clear_vec[gi]) begin
                    busy_ch_reg  <= 1'b0;
                end
            end

            assign clear_vec[gi] = (state_reg == S_DONE) && (ch_reg == CH_W'(gi));
            assign busy_vec[gi]  = busy_ch_reg;
            assign cfg_src[gi]   = src_ch_reg;
            assign cfg_dst[gi]   = dst_ch_reg;
            assign cfg_len[gi]   = len_ch_reg;
            assign cfg_fixed[gi] = fixed_ch_reg;
        end
    endgenerate

    // Lowest-index pending channel wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (busy_vec[i]) begin
                grant_valid = 1'b1;
                grant_ch    = CH_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    state_next = (cfg_len[grant_ch] == '0) ? S_DONE : S_HALT;
                end
            end
            S_HALT: begin
                // RDY only stalls the 6502 on a read cycle.
                if (i_cpu_rw) begin
`ifdef CPU_BUS_DMA_ALIGN_EN
                    state_next = S_ALIGN;
`else
                    state_next = S_READ;
`endif
                end
            end
`ifdef CPU_BUS_DMA_ALIGN_EN
            S_ALIGN: begin
                // Next cycle is even when the current parity is odd.
                if (parity_reg) begin
                    state_next = S_READ;
                end
            end
`endif
            S_READ:  state_next = S_WRITE;
            S_WRITE: state_next = (rem_reg > LEN_W'(1)) ? S_READ : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Transfer datapath
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ch_reg        <= '0;
            src_reg       <= '0;
            dst_reg       <= '0;
            rem_reg       <= '0;
            fixed_reg     <= 1'b0;
            byte_reg      <= '0;
            addr_last_reg <= '0;
            data_last_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        ch_reg    <= grant_ch;
                        src_reg   <= cfg_src[grant_ch];
                        dst_reg   <= cfg_dst[grant_ch];
                        rem_reg   <= cfg_len[grant_ch];
                        fixed_reg <= cfg_fixed[grant_ch];
                    end
                end
                S_READ: begin
                    byte_reg      <= i_data;
                    addr_last_reg <= src_reg;
                end
                S_WRITE: begin
                    addr_last_reg <= dst_reg;
                    data_last_reg <= byte_reg;
                    src_reg       <= src_reg + ADDR_W'(1);
                    if (!fixed_reg) begin
                        dst_reg <= dst_reg + ADDR_W'(1);
                    end
                    rem_reg       <= rem_reg - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_rw       = 1'b1;
        o_address  = addr_last_reg;
        o_data     = data_last_reg;
        o_bus_en   = 1'b0;
        o_cpu_halt = 1'b0;
        o_busy     = busy_vec;
        o_done     = '0;
        case (state_reg)
            S_HALT: begin
                o_cpu_halt = 1'b1;
            end
`ifdef CPU_BUS_DMA_ALIGN_EN
            S_ALIGN: begin
                o_cpu_halt = 1'b1;
            end
`endif
            S_READ: begin
                o_cpu_halt = 1'b1;
                o_bus_en   = 1'b1;
                o_address  = src_reg;
            end
            S_WRITE: begin
                o_cpu_halt = 1'b1;
                o_bus_en   = 1'b1;
                o_rw       = 1'b0;
                o_address  = dst_reg;
                o_data     = byte_reg;
            end
            S_DONE: begin
                o_done[ch_reg] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
